// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: FSM state encodings,
// decoded opcode classes, RV32 base opcode constants and writeback-select codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } op_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: maps the 7-bit opcode field to an
// instruction class and flags whether the opcode is one the controller supports.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] op_class,
    output logic       legal
);

    op_class_t w_class;

    // Classify the opcode; unknown encodings report class R and legal=0
    always_comb begin
        w_class = CLS_R;
        legal   = 1'b1;
        case (opcode)
            OPC_R:      w_class = CLS_R;
            OPC_I:      w_class = CLS_I;
            OPC_LOAD:   w_class = CLS_LOAD;
            OPC_STORE:  w_class = CLS_STORE;
            OPC_BRANCH: w_class = CLS_BRANCH;
            OPC_JAL:    w_class = CLS_JAL;
            OPC_JALR:   w_class = CLS_JALR;
            OPC_LUI:    w_class = CLS_LUI;
            OPC_AUIPC:  w_class = CLS_AUIPC;
            default: begin
                w_class = CLS_R;
                legal   = 1'b0;
            end
        endcase
    end

    assign op_class = w_class;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP
// (illegal_insn=1 until reset); without it they retire as a NOP from DECODE.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int unsigned FETCH_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       ins_read_enable,
    output logic       ir_load,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       reg_write_enable,
    output logic       data_read_enable,
    output logic       data_write_enable,
    output logic       retired,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       illegal_insn
);

    localparam logic [2:0] LAST_FETCH = 3'(FETCH_LAT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_fetch_cnt;
    op_class_t  r_class;
    logic [3:0] w_dec_class;
    logic       w_dec_legal;
    logic       w_fetch_done;
    logic       w_is_jump;

    opcode_decoder u_dec (
        .opcode   (opcode),
        .op_class (w_dec_class),
        .legal    (w_dec_legal)
    );

    assign w_fetch_done = run && (r_fetch_cnt == LAST_FETCH);
    assign w_is_jump    = (r_class == CLS_JAL) || (r_class == CLS_JALR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next_state;
    end

    // Fetch wait counter: counts run-qualified FETCH cycles, cleared when run drops
    always_ff @(posedge clk) begin
        if (reset)
            r_fetch_cnt <= '0;
        else if (r_state == ST_FETCH && run && !w_fetch_done)
            r_fetch_cnt <= r_fetch_cnt + 3'd1;
        else
            r_fetch_cnt <= '0;
    end

    // Capture the instruction class once, in DECODE; later opcode changes are ignored
    always_ff @(posedge clk) begin
        if (reset)
            r_class <= CLS_R;
        else if (r_state == ST_DECODE)
            r_class <= op_class_t'(w_dec_class);
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:  if (w_fetch_done) w_next_state = ST_DECODE;
            ST_DECODE: begin
                if (w_dec_legal) w_next_state = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
                else             w_next_state = ST_TRAP;
`else
                else             w_next_state = ST_FETCH;
`endif
            end
            ST_EXEC: begin
                if (r_class == CLS_BRANCH)
                    w_next_state = ST_FETCH;
                else if (r_class == CLS_LOAD || r_class == CLS_STORE)
                    w_next_state = ST_MEM;
                else
                    w_next_state = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready)
                    w_next_state = (r_class == CLS_STORE) ? ST_FETCH : ST_WB;
            end
            ST_WB:   w_next_state = ST_FETCH;
            ST_TRAP: w_next_state = ST_TRAP;
            default: w_next_state = ST_FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        ins_read_enable   = 1'b0;
        ir_load           = 1'b0;
        pc_write          = 1'b0;
        pc_sel            = 1'b0;
        reg_write_enable  = 1'b0;
        data_read_enable  = 1'b0;
        data_write_enable = 1'b0;
        retired           = 1'b0;
        wb_sel            = WB_ALU;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    ins_read_enable = run;
                    ir_load         = w_fetch_done;
                end
                ST_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                    if (!w_dec_legal) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                    end
`endif
                end
                ST_EXEC: begin
                    if (r_class == CLS_BRANCH) begin
                        pc_write = 1'b1;
                        pc_sel   = branch_taken;
                        retired  = 1'b1;
                    end
                end
                ST_MEM: begin
                    data_read_enable  = (r_class == CLS_LOAD);
                    data_write_enable = (r_class == CLS_STORE);
                    if (mem_ready && r_class == CLS_STORE) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_write_enable = 1'b1;
                    pc_write         = 1'b1;
                    retired          = 1'b1;
                    pc_sel           = w_is_jump;
                    if (r_class == CLS_LOAD) wb_sel = WB_MEM;
                    else if (w_is_jump)      wb_sel = WB_PC4;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_insn = !reset && (r_state == ST_TRAP);
`else
    assign illegal_insn = 1'b0;
`endif

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: two instances (FETCH_LAT=1 and 3),
// directed latency checks plus a randomized instruction stream compared against
// a per-instruction cycle-trace model. Honors ILLEGAL_TRAP_EN the same way as the RTL.
module tb_multicycle_controller;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    // Expected/actual output vector bit positions
    localparam int B_IRE = 13;
    localparam int B_IRL = 12;
    localparam int B_PCW = 11;
    localparam int B_PCS = 10;
    localparam int B_RWE = 9;
    localparam int B_DRE = 8;
    localparam int B_DWE = 7;
    localparam int B_RET = 6;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       run [2];
    logic [6:0] opc [2];
    logic       bt  [2];
    logic       mr  [2];
    logic       ire [2];
    logic       irl [2];
    logic       pcw [2];
    logic       pcs [2];
    logic       rwe [2];
    logic       dre [2];
    logic       dwe [2];
    logic       ret [2];
    logic [1:0] wbs [2];
    logic [2:0] st  [2];
    logic       ill [2];

    multicycle_controller #(.FETCH_LAT(LAT0)) dut0 (
        .clk(clk), .reset(rst[0]), .run(run[0]), .opcode(opc[0]),
        .branch_taken(bt[0]), .mem_ready(mr[0]),
        .ins_read_enable(ire[0]), .ir_load(irl[0]), .pc_write(pcw[0]), .pc_sel(pcs[0]),
        .reg_write_enable(rwe[0]), .data_read_enable(dre[0]), .data_write_enable(dwe[0]),
        .retired(ret[0]), .wb_sel(wbs[0]), .state(st[0]), .illegal_insn(ill[0])
    );

    multicycle_controller #(.FETCH_LAT(LAT1)) dut1 (
        .clk(clk), .reset(rst[1]), .run(run[1]), .opcode(opc[1]),
        .branch_taken(bt[1]), .mem_ready(mr[1]),
        .ins_read_enable(ire[1]), .ir_load(irl[1]), .pc_write(pcw[1]), .pc_sel(pcs[1]),
        .reg_write_enable(rwe[1]), .data_read_enable(dre[1]), .data_write_enable(dwe[1]),
        .retired(ret[1]), .wb_sel(wbs[1]), .state(st[1]), .illegal_insn(ill[1])
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        run;
        logic [6:0]  opc;
        logic        bt;
        logic        mr;
        logic [13:0] exp;
    } cyc_t;

    cyc_t plan[$];

    function automatic logic [13:0] outs(input int w);
        return {ire[w], irl[w], pcw[w], pcs[w], rwe[w], dre[w], dwe[w], ret[w],
                wbs[w], st[w], ill[w]};
    endfunction

    function automatic logic [13:0] mk(input logic [2:0] s, input logic i_ire, input logic i_irl,
                                       input logic i_pcw, input logic i_pcs, input logic i_rwe,
                                       input logic i_dre, input logic i_dwe, input logic i_ret,
                                       input logic [1:0] i_wbs, input logic i_ill);
        return {i_ire, i_irl, i_pcw, i_pcs, i_rwe, i_dre, i_dwe, i_ret, i_wbs, s, i_ill};
    endfunction

    function automatic logic rb();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    function automatic logic [6:0] r7();
        logic [6:0] v;
        v = 7'($urandom);
        return v;
    endfunction

    // Instruction class from the opcode table: 0 R,1 I,2 LOAD,3 STORE,4 BRANCH,
    // 5 JAL,6 JALR,7 LUI,8 AUIPC, -1 illegal
    function automatic int cls(input logic [6:0] o);
        case (o)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            7'b1100111: return 6;
            7'b0110111: return 7;
            7'b0010111: return 8;
            default:    return -1;
        endcase
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (ire irl pcw pcs rwe dre dwe ret wbs[2] st[3] ill)",
                     name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic push(input logic r, input logic [6:0] o, input logic b, input logic m,
                        input logic [13:0] e);
        cyc_t c;
        c.run = r; c.opc = o; c.bt = b; c.mr = m; c.exp = e;
        plan.push_back(c);
    endtask

    // Append the cycle-by-cycle trace of one instruction to the plan
    task automatic plan_insn(input int unsigned lat, input logic [6:0] op, input int unsigned idle,
                             input int unsigned abort_k, input int unsigned w);
        int   c;
        logic b;
        logic jmp;
        logic [1:0] ws;
        c = cls(op);
        for (int unsigned i = 0; i < idle; i++)
            push(1'b0, r7(), rb(), rb(), '0);
        if (abort_k > 0) begin
            for (int unsigned i = 0; i < abort_k; i++)
                push(1'b1, r7(), rb(), rb(), mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
            push(1'b0, r7(), rb(), rb(), '0);
        end
        for (int unsigned f = 0; f < lat; f++)
            push(1'b1, r7(), rb(), rb(), mk(3'd0, 1, (f == lat - 1), 0, 0, 0, 0, 0, 0, 2'd0, 0));
        if (c < 0) begin
`ifndef ILLEGAL_TRAP_EN
            push(rb(), op, rb(), rb(), mk(3'd1, 0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 0));
`endif
            return;
        end
        push(rb(), op, rb(), rb(), mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        if (c == 4) begin
            b = rb();
            push(rb(), r7(), b, rb(), mk(3'd2, 0, 0, 1, b, 0, 0, 0, 1, 2'd0, 0));
            return;
        end
        push(rb(), r7(), rb(), rb(), mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        if (c == 2 || c == 3) begin
            for (int unsigned i = 0; i < w; i++)
                push(rb(), r7(), rb(), 1'b0, mk(3'd3, 0, 0, 0, 0, 0, (c == 2), (c == 3), 0, 2'd0, 0));
            push(rb(), r7(), rb(), 1'b1,
                 mk(3'd3, 0, 0, (c == 3), 0, 0, (c == 2), (c == 3), (c == 3), 2'd0, 0));
            if (c == 3) return;
        end
        jmp = (c == 5 || c == 6);
        ws  = (c == 2) ? 2'd1 : (jmp ? 2'd2 : 2'd0);
        push(rb(), r7(), rb(), rb(), mk(3'd4, 0, 0, 1, jmp, 1, 0, 0, 1, ws, 0));
    endtask

    // Hold reset over one rising edge (with distracting inputs), then check the reset state
    task automatic do_reset(input int w);
        @(negedge clk);
        rst[w] = 1'b1; run[w] = 1'b0; opc[w] = r7(); bt[w] = 1'b1; mr[w] = 1'b1;
        @(negedge clk);
        #1 check($sformatf("reset_state_%0d", w), outs(w), '0);
    endtask

    task automatic run_plan(input int w);
        cyc_t c;
        int   n;
        n = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            rst[w] = 1'b0; run[w] = c.run; opc[w] = c.opc; bt[w] = c.bt; mr[w] = c.mr;
            #1 check($sformatf("trace%0d_cyc%0d", w, n), outs(w), c.exp);
            n++;
        end
    endtask

    // Constant stimulus from reset release; reports the first cycle showing retired
    task automatic meas(input int w, input logic [6:0] op, input logic b, input int mr_cycle,
                        output int ret_cyc, output logic [13:0] at_ret,
                        output int dre_cnt, output logic rwe_any);
        logic [13:0] o;
        ret_cyc = 0; at_ret = '0; dre_cnt = 0; rwe_any = 1'b0;
        for (int c = 1; c <= 30 && ret_cyc == 0; c++) begin
            @(negedge clk);
            rst[w] = 1'b0; run[w] = 1'b1; opc[w] = op; bt[w] = b; mr[w] = (c == mr_cycle);
            #1 o = outs(w);
            if (o[B_DRE]) dre_cnt++;
            if (o[B_RWE]) rwe_any = 1'b1;
            if (o[B_RET]) begin
                ret_cyc = c;
                at_ret  = o;
            end
        end
    endtask

    logic [6:0] ops [10];

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rc;
        int          dc;
        logic        ra;
        logic [13:0] ar;
        int unsigned nops;
        int unsigned lat;
        int unsigned ak;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; run[i] = 1'b0; opc[i] = '0; bt[i] = 1'b0; mr[i] = 1'b0;
        end
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ops[6] = 7'b1100111; ops[7] = 7'b0110111; ops[8] = 7'b0010111;
        ops[9] = 7'b0000000;
`ifdef ILLEGAL_TRAP_EN
        nops = 9;
`else
        nops = 10;
`endif

        // R-type, FETCH_LAT=1: retire on cycle 4 with register write, ALU writeback
        do_reset(0);
        meas(0, 7'b0110011, 1'b0, 0, rc, ar, dc, ra);
        check_int("rtype_latency", rc, 4);
        check_int("rtype_rwe", int'(ar[B_RWE]), 1);
        check_int("rtype_wbsel", int'(ar[5:4]), 0);

        // Taken branch: retire on cycle 3, pc_sel=1, never a register write
        do_reset(0);
        meas(0, 7'b1100011, 1'b1, 0, rc, ar, dc, ra);
        check_int("branch_latency", rc, 3);
        check_int("branch_pcsel", int'(ar[B_PCS]), 1);
        check_int("branch_no_rwe", int'(ra), 0);

        // Load with 3 wait cycles: ready on cycle 7, 4 read cycles, WB retires on cycle 8
        do_reset(0);
        meas(0, 7'b0000011, 1'b0, 7, rc, ar, dc, ra);
        check_int("load_latency", rc, 8);
        check_int("load_dre_cycles", dc, 4);
        check_int("load_wbsel", int'(ar[5:4]), 1);

        // FETCH_LAT=3 instance: R-type retires on cycle 6, branch on cycle 5
        do_reset(1);
        meas(1, 7'b0110011, 1'b0, 0, rc, ar, dc, ra);
        check_int("lat3_rtype_latency", rc, 6);
        do_reset(1);
        meas(1, 7'b1100011, 1'b0, 0, rc, ar, dc, ra);
        check_int("lat3_branch_latency", rc, 5);
        check_int("lat3_branch_pcsel", int'(ar[B_PCS]), 0);

        // Illegal opcode
        do_reset(0);
`ifdef ILLEGAL_TRAP_EN
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rst[0] = 1'b0; run[0] = 1'b1; opc[0] = (c <= 2) ? 7'b0000000 : 7'b0110011;
            bt[0] = 1'b1; mr[0] = 1'b1;
        end
        #1 check("trap_hold", outs(0), 14'b00000000_00_101_1);
        do_reset(0);
`else
        meas(0, 7'b0000000, 1'b0, 0, rc, ar, dc, ra);
        check_int("illegal_nop_latency", rc, 2);
        check_int("illegal_nop_pcw", int'(ar[B_PCW]), 1);
        check_int("illegal_flag", int'(ar[0]), 0);
        do_reset(0);
`endif

        // Reset during a STORE MEM wait
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            rst[0] = 1'b0; run[0] = 1'b1; opc[0] = 7'b0100011; bt[0] = 1'b0; mr[0] = 1'b0;
        end
        #1 check("store_mem_wait", outs(0), mk(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0));
        @(negedge clk);
        rst[0] = 1'b1; run[0] = 1'b0;
        @(negedge clk);
        #1 check("reset_mid_mem", outs(0), '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst[0] = 1'b0; run[0] = 1'b0; mr[0] = 1'b1;
            #1 check($sformatf("idle_after_reset%0d", c), outs(0), '0);
        end

        // Randomized instruction streams on both instances
        for (int w = 0; w < 2; w++) begin
            lat = (w == 0) ? LAT0 : LAT1;
            do_reset(w);
            for (int k = 0; k < 40; k++) begin
                ak = 0;
                if (lat > 1 && $urandom_range(0, 3) == 0) ak = $urandom_range(1, lat - 1);
                plan_insn(lat, ops[$urandom_range(0, nops - 1)], $urandom_range(0, 2), ak,
                          $urandom_range(0, 3));
            end
            run_plan(w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
